pipelined_add_sub: RTL and testbench

//   Parametrised, pipelined add/subtract unit with NZVC flags; successor to the single-cycle 64-bit ripple adder.

---
 rtl/alu_pkg.sv | 4 +
 rtl/add_slice.sv | 24 ++
 rtl/pipelined_add_sub.sv | 114 +++++++++++
 tb/tb_pipelined_add_sub.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: add/subtract opcode encoding shared by the adder and ALU decode
package alu_pkg;
  typedef enum logic [1:0] {ADD = 2'b00, SUB = 2'b01, ADC = 2'b10, SBC = 2'b11} addsub_op_t;
endpackage

// File: rtl/add_slice.sv
// add_slice: combinational W-bit ripple-carry slice; c_msb is the carry into the top bit
module add_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);
  logic [W:0] c;
  always_comb begin
    c = '0;
    sum = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end
  assign cout = c[W];
  assign c_msb = c[W-1];
endmodule

// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: STAGES-deep add/sub with NZVC flags; stage k ripples slice k and
// carries the unprocessed upper operand bits and the finished lower sum bits forward.
module pipelined_add_sub
  import alu_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] tag_out,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);
  localparam int CHUNK = WIDTH / STAGES;
  if (STAGES < 1 || WIDTH % STAGES != 0) begin : g_chk
    $error("pipelined_add_sub: WIDTH must be a multiple of STAGES");
  end
  addsub_op_t op_e;
  logic advance, c0;
  logic [WIDTH-1:0] b_eff;
  assign op_e = addsub_op_t'(op);
  assign b_eff = (op_e == SUB || op_e == SBC) ? ~b : b;
  assign c0 = op_e == ADD ? 1'b0 : op_e == SUB ? 1'b1 : cin;
  // the whole pipe stalls together; bubbles are not squeezed out
  assign advance = ~out_valid | out_ready;
  assign in_ready = advance;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int REM = (STAGES - k) * CHUNK;
    logic [REM-1:0] a_p, b_p;
    logic c_p, v_p, cout, c_msb, v_q, c_q;
    logic [TAG_W-1:0] t_p, t_q;
    logic [CHUNK-1:0] sum;
    logic [(k+1)*CHUNK-1:0] s_d, s_q;
    if (k == 0) begin : g_in
      assign a_p = a;
      assign b_p = b_eff;
      assign c_p = c0;
      assign v_p = in_valid;
      assign t_p = tag_in;
      assign s_d = sum;
    end else begin : g_in
      assign a_p = g_st[k-1].g_op.a_q;
      assign b_p = g_st[k-1].g_op.b_q;
      assign c_p = g_st[k-1].c_q;
      assign v_p = g_st[k-1].v_q;
      assign t_p = g_st[k-1].t_q;
      assign s_d = {sum, g_st[k-1].s_q};
    end
    add_slice #(.W(CHUNK)) u_slice (
      .a(a_p[CHUNK-1:0]), .b(b_p[CHUNK-1:0]), .cin(c_p), .sum(sum), .cout(cout), .c_msb(c_msb)
    );
    // payload only loads under a valid op, so the last stage holds its outputs across bubbles
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        t_q <= '0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= v_p;
        if (v_p) begin
          c_q <= cout;
          t_q <= t_p;
          s_q <= s_d;
        end
      end
    if (k < STAGES - 1) begin : g_op
      logic [REM-CHUNK-1:0] a_q, b_q;
      logic unused_c_msb;
      assign unused_c_msb = c_msb;
      always_ff @(posedge clk or posedge reset)
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance && v_p) begin
          a_q <= a_p[REM-1:CHUNK];
          b_q <= b_p[REM-1:CHUNK];
        end
    end else begin : g_fl
      logic n_q, z_q, o_q;
      always_ff @(posedge clk or posedge reset)
        if (reset) begin
          n_q <= 1'b0;
          z_q <= 1'b0;
          o_q <= 1'b0;
        end else if (advance && v_p) begin
          n_q <= s_d[WIDTH-1];
          z_q <= ~|s_d;
          o_q <= c_msb ^ cout;
        end
    end
  end
  assign out_valid = g_st[STAGES-1].v_q;
  assign result = g_st[STAGES-1].s_q;
  assign tag_out = g_st[STAGES-1].t_q;
  assign carry_out = g_st[STAGES-1].c_q;
  assign negative = g_st[STAGES-1].g_fl.n_q;
  assign zero = g_st[STAGES-1].g_fl.z_q;
  assign overflow = g_st[STAGES-1].g_fl.o_q;
endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb_pipelined_add_sub: directed vectors, stall/reset sequences and random traffic
// scored against a wide-integer arithmetic model of add/sub with NZVC.
module tb_pipelined_add_sub;
  import alu_pkg::*;
  localparam int W = 64, S = 4, TW = 5;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_ready, cin = 1'b0, out_valid, out_ready = 1'b1;
  logic negative, zero, overflow, carry_out;
  logic [1:0] op = 2'd0;
  logic [W-1:0] a = '0, b = '0, result;
  logic [TW-1:0] tag_in = '0, tag_out;
  int errors = 0, checks = 0, delivered = 0;
  typedef struct {logic [W-1:0] r; logic [TW-1:0] t; logic [3:0] f;} exp_t;
  typedef struct {logic [1:0] op; logic [W-1:0] a, b; logic cin; logic [TW-1:0] tag; logic [W-1:0] r; logic [3:0] f;} vec_t;
  exp_t sbq[$];
  exp_t e;
  logic hold_v = 1'b0;
  logic [W-1:0] hold_r;
  logic [TW-1:0] hold_t;
  logic [3:0] hold_f;
  vec_t vt[9];

  always #5 clk = ~clk;

  pipelined_add_sub #(.WIDTH(W), .STAGES(S), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .cin(cin), .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .tag_out(tag_out), .negative(negative), .zero(zero), .overflow(overflow), .carry_out(carry_out)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Signed result in W+3 bits tells overflow; unsigned compare tells carry/no-borrow.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic [TW-1:0] t);
    exp_t m;
    logic k, c;
    logic [W+2:0] sw;
    logic [W:0] uw;
    k = (o == ADD) ? 1'b0 : (o == SUB) ? 1'b1 : ci;
    if (o == ADD || o == ADC) begin
      sw = {{3{x[W-1]}}, x} + {{3{y[W-1]}}, y} + {{(W+2){1'b0}}, k};
      uw = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, k};
      c = uw[W];
    end else begin
      sw = {{3{x[W-1]}}, x} - {{3{y[W-1]}}, y} - {{(W+2){1'b0}}, ~k};
      c = {1'b0, x} >= ({1'b0, y} + {{W{1'b0}}, ~k});
    end
    m.r = sw[W-1:0];
    m.t = t;
    m.f = {m.r[W-1], m.r == '0, sw[W+2:W-1] != {4{sw[W-1]}}, c};
    return m;
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 4))
      0: v = {$urandom, $urandom};
      1: v = '1;
      2: v = '0;
      3: begin v = '1; v = v << $urandom_range(0, W - 1); end
      default: begin v = 1; v = v << $urandom_range(0, W - 1); end
    endcase
    return v;
  endfunction

  // scoreboard: transfers are sampled on the falling edge, before the rising edge that commits them
  always begin
    @(negedge clk);
    if (reset) hold_v = 1'b0;
    else begin
      if (hold_v) begin
        chk("hold_valid", W'(out_valid), 64'd1);
        chk("hold_result", result, hold_r);
        chk("hold_tag", W'(tag_out), W'(hold_t));
        chk("hold_flags", W'({negative, zero, overflow, carry_out}), W'(hold_f));
      end
      hold_v = out_valid && !out_ready;
      hold_r = result;
      hold_t = tag_out;
      hold_f = {negative, zero, overflow, carry_out};
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_output: got tag %h with nothing outstanding", tag_out);
        end else begin
          e = sbq.pop_front();
          chk("sb_result", result, e.r);
          chk("sb_tag", W'(tag_out), W'(e.t));
          chk("sb_nzvc", W'({negative, zero, overflow, carry_out}), W'(e.f));
          delivered++;
        end
      end
      if (in_valid && in_ready) sbq.push_back(model(op, a, b, cin, tag_in));
    end
  end

  task automatic drive(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input logic [TW-1:0] t);
    int n = 0;
    in_valid = 1'b1; op = o; a = x; b = y; cin = ci; tag_in = t;
    do begin @(negedge clk); n++; end while (!in_ready && n < 50);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int n = 1;
    drive(v.op, v.a, v.b, v.cin, v.tag);
    @(negedge clk);
    while (!out_valid && n < 20) begin @(posedge clk); n++; @(negedge clk); end
    chk("latency", W'(n), W'(S));
    chk("vec_result", result, v.r);
    chk("vec_tag", W'(tag_out), W'(v.tag));
    chk("vec_nzvc", W'({negative, zero, overflow, carry_out}), W'(v.f));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 100) begin @(negedge clk); n++; end
    chk("drain_outstanding", W'(sbq.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation got no end expected finish");
    $fatal(1);
  end

  initial begin
    int d0;
    vt[0] = '{ADD, 64'h10, 64'h1, 1'b1, 5'd3, 64'h11, 4'b0000};
    vt[1] = '{ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 5'd1, 64'h8000_0000_0000_0000, 4'b1010};
    vt[2] = '{SUB, 64'h5, 64'h5, 1'b0, 5'd2, 64'h0, 4'b0101};
    vt[3] = '{SUB, 64'h0, 64'h1, 1'b1, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000};
    vt[4] = '{ADC, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 5'd5, 64'h0, 4'b0101};
    vt[5] = '{SBC, 64'hA, 64'h3, 1'b0, 5'd6, 64'h6, 4'b0001};
    vt[6] = '{SUB, 64'h8000_0000_0000_0000, 64'h1, 1'b0, 5'd7, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
    vt[7] = '{ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd8, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1001};
    vt[8] = '{ADC, 64'h0000_0000_FFFF_FFFF, 64'h0, 1'b1, 5'd9, 64'h0000_0001_0000_0000, 4'b0000};
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", W'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_tag", W'(tag_out), 64'd0);
    chk("rst_nzvc", W'({negative, zero, overflow, carry_out}), 64'd0);
    chk("rst_in_ready", W'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) run_vec(vt[i]);

    d0 = delivered;
    fork
      for (int i = 0; i < 8; i++)
        drive(2'($urandom), pick(), pick(), 1'($urandom), TW'(i));
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", W'(in_ready), 64'd0);
          @(posedge clk);
        end
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_delivered", W'(delivered - d0), 64'd8);

    for (int i = 0; i < 4; i++) drive(ADD, pick(), pick(), 1'b0, TW'(20 + i));
    chk("pre_reset_valid", W'(out_valid), 64'd1);
    reset = 1'b1;
    sbq.delete();
    #1;
    chk("async_rst_valid", W'(out_valid), 64'd0);
    chk("async_rst_result", result, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    d0 = delivered;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_idle", W'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    run_vec(vt[1]);
    chk("post_rst_delivered", W'(delivered - d0), 64'd1);

    for (int c = 0; c < 3000; c++) begin
      in_valid = $urandom_range(0, 9) < 7;
      op = 2'($urandom);
      a = pick();
      b = pick();
      cin = 1'($urandom);
      tag_in = TW'($urandom);
      out_ready = $urandom_range(0, 9) < 7;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
